bus_resp: RTL

- Memory-side responder for the CPU core's address/data bus. It receives the unregistered 16-bit address, write enable and write data that the core drives each cycle.
- It returns read data on DB one cycle later and drives RDY to stall the core.
- It serves local block RAM (mirrored) and bridges one I/O page to a slow external peripheral through a req/ack handshake with timeout.

---
 rtl/bus_resp_pkg.sv | 20 ++
 rtl/resp_ram.sv | 30 +++
 rtl/bus_resp.sv | 138 +++++++++++++
 3 files changed

// File: rtl/bus_resp_pkg.sv
// Shared definitions for the bus responder: FSM state type, I/O window default,
// timeout fill value and the DB reset value, plus the I/O page decode helper.
package bus_resp_pkg;

  // Responder FSM: StIdle accepts a new access each edge, StReq waits on the peripheral.
  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StReq  = 1'b1
  } state_e;

  localparam logic [7:0] IoPageDefault = 8'hFE;
  localparam logic [7:0] TimeoutData   = 8'hFF;
  localparam logic [7:0] DbResetVal    = 8'h00;

  // True when the address falls in the 256-byte I/O window.
  function automatic logic is_io_addr(input logic [15:0] addr, input logic [7:0] page);
    return addr[15:8] == page;
  endfunction

endpackage

// File: rtl/resp_ram.sv
// Single-port synchronous byte RAM, write-first, 2^AW bytes.
// Ports:
//   clk  - clock
//   we   - write enable; din is stored at addr and also returned on dout
//   addr - byte address
//   din  - write data
//   dout - registered read data (one-cycle latency)
module resp_ram #(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout
);

  logic [7:0] mem [2**AW];

  // No reset on purpose so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
      dout      <= din;
    end else begin
      dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/bus_resp.sv
// Memory-side responder for the core address/data bus. Serves a mirrored local
// block RAM with one-cycle read latency and bridges one I/O page to a slow
// peripheral through a req/ack handshake with timeout.
// Ports:
//   clk, rst_n         - clock, synchronous active-low reset
//   AB, WE, DO         - unregistered address / write enable / write data from the core
//   DB                 - read data to the core (registered)
//   RDY                - 1 when an access is accepted at the coming edge
//   io_req             - peripheral request, high for the whole I/O access
//   io_we, io_addr,
//   io_wdata           - access attributes latched when the I/O access is accepted
//   io_rdata, io_ack   - peripheral read data and one-cycle completion pulse
module bus_resp
  import bus_resp_pkg::*;
#(
  parameter int unsigned AW       = 12,
  parameter logic [7:0]  IO_PAGE  = IoPageDefault,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] AB,
  input  logic        WE,
  input  logic [7:0]  DO,
  output logic [7:0]  DB,
  output logic        RDY,
  output logic        io_req,
  output logic        io_we,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  input  logic        io_ack
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] db_q, db_d;
  logic       ram_sel_q, ram_sel_d;
  logic       io_req_q, io_req_d;
  logic       io_we_q, io_we_d;
  logic [7:0] io_addr_q, io_addr_d;
  logic [7:0] io_wdata_q, io_wdata_d;
  logic [7:0] ram_dout;
  logic       is_io;
  logic       ram_we;

  assign RDY    = (state_q == StIdle);
  assign is_io  = is_io_addr(AB, IO_PAGE);
  assign ram_we = RDY && !is_io && WE;

  // After a RAM access DB comes straight from the RAM output register; otherwise
  // from db_q, which always captures the value currently shown so DB holds.
  assign DB = ram_sel_q ? ram_dout : db_q;

  assign io_req   = io_req_q;
  assign io_we    = io_we_q;
  assign io_addr  = io_addr_q;
  assign io_wdata = io_wdata_q;

  // Reads during REQ are harmless: the RAM output is only selected after a RAM access.
  resp_ram #(
    .AW(AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (AB[AW-1:0]),
    .din  (DO),
    .dout (ram_dout)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    db_d       = DB;
    ram_sel_d  = 1'b0;
    io_req_d   = io_req_q;
    io_we_d    = io_we_q;
    io_addr_d  = io_addr_q;
    io_wdata_d = io_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (is_io) begin
          state_d    = StReq;
          io_req_d   = 1'b1;
          io_addr_d  = AB[7:0];
          io_we_d    = WE;
          io_wdata_d = DO;
          cnt_d      = 8'h00;
        end else begin
          ram_sel_d  = 1'b1;
        end
      end
      StReq: begin
        if (io_ack) begin
          state_d  = StIdle;
          io_req_d = 1'b0;
          db_d     = io_we_q ? io_wdata_q : io_rdata;
        end else if (cnt_q == CntLast) begin
          state_d  = StIdle;
          io_req_d = 1'b0;
          db_d     = io_we_q ? io_wdata_q : TimeoutData;
        end else begin
          cnt_d    = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d  = StIdle;
        io_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 8'h00;
      db_q       <= DbResetVal;
      ram_sel_q  <= 1'b0;
      io_req_q   <= 1'b0;
      io_we_q    <= 1'b0;
      io_addr_q  <= 8'h00;
      io_wdata_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      db_q       <= db_d;
      ram_sel_q  <= ram_sel_d;
      io_req_q   <= io_req_d;
      io_we_q    <= io_we_d;
      io_addr_q  <= io_addr_d;
      io_wdata_q <= io_wdata_d;
    end
  end

endmodule
